// File: rtl/sam_pkg.sv
// Shared types and constants for the SAM line transmitter.
package sam_pkg;

    localparam int unsigned N_W            = 4;
    localparam int unsigned T_LONG_DFLT    = 20;
    localparam int unsigned T_SHORT_DFLT   = 12;
    localparam int unsigned IDLE_GAP_DFLT  = 4;

    typedef enum logic [3:0] {
        IDLE,
        CFG_LEAD,
        CFG_SHIFT,
        CFG_GUARD,
        READY,
        BIT_HI,
        BIT_LO,
        STOP_HI,
        GAP
    } state_e;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sam_pwm_bit.sv
// Pulse-width coder for one bit: long/short high then short/long low.
// With stop set, only the short high half is produced and done fires at its end.
module sam_pwm_bit
    import sam_pkg::*;
#(
    parameter int unsigned T_LONG  = T_LONG_DFLT,
    parameter int unsigned T_SHORT = T_SHORT_DFLT,
    parameter int unsigned CNT_W   = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic bit_val,
    input  logic stop,
    output logic lvl_c,
    output logic hi_end_c,
    output logic done_c
);

    logic             active_q, active_d;
    logic             hi_q, hi_d;
    logic             bit_q, bit_d;
    logic             stop_q, stop_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_len, lo_len;

    assign hi_len = bit_q ? CNT_W'(T_LONG)  : CNT_W'(T_SHORT);
    assign lo_len = bit_q ? CNT_W'(T_SHORT) : CNT_W'(T_LONG);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q <= 1'b0;
            hi_q     <= 1'b0;
            bit_q    <= 1'b0;
            stop_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            hi_q     <= hi_d;
            bit_q    <= bit_d;
            stop_q   <= stop_d;
            cnt_q    <= cnt_d;
        end
    end

    // cnt holds the number of cycles already spent in the current half, starting at 1
    always_comb begin
        active_d = active_q;
        hi_d     = hi_q;
        bit_d    = bit_q;
        stop_d   = stop_q;
        cnt_d    = cnt_q;
        if (start) begin
            active_d = 1'b1;
            hi_d     = 1'b1;
            bit_d    = bit_val;
            stop_d   = stop;
            cnt_d    = CNT_W'(1);
        end else if (active_q) begin
            if (hi_q) begin
                if (cnt_q == hi_len) begin
                    hi_d  = 1'b0;
                    cnt_d = CNT_W'(1);
                    if (stop_q) begin
                        active_d = 1'b0;
                        cnt_d    = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (cnt_q == lo_len) begin
                active_d = 1'b0;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign hi_end_c = active_q && hi_q && (cnt_q == hi_len);
    assign done_c   = active_q && (hi_q ? (hi_end_c && stop_q) : (cnt_q == lo_len));
    assign lvl_c    = hi_d;

endmodule

// File: rtl/sam_tx.sv
// SAM line transmitter: serial configuration with mode high, then
// pulse-width-coded messages each closed by a stop pulse and idle gap.
module sam_tx
    import sam_pkg::*;
#(
    parameter int unsigned KEY_W    = 8,
    parameter int unsigned MSG_W    = 8,
    parameter int unsigned T_LONG   = T_LONG_DFLT,
    parameter int unsigned T_SHORT  = T_SHORT_DFLT,
    parameter int unsigned IDLE_GAP = IDLE_GAP_DFLT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic [N_W-1:0]   cfg_n,
    input  logic [KEY_W-1:0] cfg_d,
    input  logic [KEY_W-1:0] cfg_capsn,
    input  logic             msg_valid,
    input  logic [MSG_W-1:0] msg_data,
    output logic             msg_ready,
    output logic             str,
    output logic             mode,
    output logic             busy,
    output logic             cfg_done,
    output logic             cfg_err
);

    localparam int unsigned SR_W  = N_W + 2 * KEY_W;
    localparam int unsigned SH_W  = $clog2(max2(SR_W, IDLE_GAP) + 1);
    localparam int unsigned CNT_W = $clog2(max2(T_LONG, IDLE_GAP) + 1);
    localparam int unsigned IDX_W = (MSG_W > 1) ? $clog2(MSG_W) : 1;

    state_e           state_q, state_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic [N_W-1:0]   n_q, n_d;
    logic [SH_W-1:0]  cnt_q, cnt_d;
    logic [MSG_W-1:0] msg_q, msg_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             cfg_done_d, cfg_err_d;
    logic             str_d, mode_d, busy_d, msg_ready_d;
    logic             pwm_start, pwm_bit, pwm_stop;
    logic             pwm_lvl, pwm_hi_end, pwm_done;
    logic [IDX_W-1:0] first_idx;

    assign first_idx = IDX_W'(n_q - N_W'(1));

    sam_pwm_bit #(
        .T_LONG  (T_LONG),
        .T_SHORT (T_SHORT),
        .CNT_W   (CNT_W)
    ) u_pwm (
        .clk      (clk),
        .reset    (reset),
        .start    (pwm_start),
        .bit_val  (pwm_bit),
        .stop     (pwm_stop),
        .lvl_c    (pwm_lvl),
        .hi_end_c (pwm_hi_end),
        .done_c   (pwm_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            n_q       <= '0;
            cnt_q     <= '0;
            msg_q     <= '0;
            idx_q     <= '0;
            str       <= 1'b0;
            mode      <= 1'b0;
            busy      <= 1'b0;
            msg_ready <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            msg_q     <= msg_d;
            idx_q     <= idx_d;
            str       <= str_d;
            mode      <= mode_d;
            busy      <= busy_d;
            msg_ready <= msg_ready_d;
            cfg_done  <= cfg_done_d;
            cfg_err   <= cfg_err_d;
        end
    end

    // Outputs are computed from the next state so each registered level lines up with its state
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        msg_d      = msg_q;
        idx_d      = idx_q;
        cfg_done_d = cfg_done;
        cfg_err_d  = cfg_err;
        pwm_start  = 1'b0;
        pwm_bit    = 1'b0;
        pwm_stop   = 1'b0;

        case (state_q)
            IDLE, READY: begin
                if (cfg_start) begin
                    state_d    = CFG_LEAD;
                    sr_d       = {cfg_n, cfg_d, cfg_capsn};
                    n_d        = cfg_n;
                    cnt_d      = '0;
                    cfg_err_d  = (cfg_n == '0) || (32'(cfg_n) > MSG_W);
                    cfg_done_d = 1'b0;
                end else if ((state_q == READY) && msg_valid && msg_ready) begin
                    state_d   = BIT_HI;
                    msg_d     = msg_data;
                    idx_d     = first_idx;
                    pwm_start = 1'b1;
                    pwm_bit   = msg_data[first_idx];
                end
            end
            CFG_LEAD: state_d = CFG_SHIFT;
            CFG_SHIFT: begin
                if (cnt_q == SH_W'(SR_W - 1)) begin
                    state_d = CFG_GUARD;
                end else begin
                    cnt_d = cnt_q + SH_W'(1);
                end
            end
            CFG_GUARD: begin
                state_d    = READY;
                cfg_done_d = 1'b1;
            end
            BIT_HI: begin
                if (pwm_hi_end) begin
                    state_d = BIT_LO;
                end
            end
            BIT_LO: begin
                if (pwm_done) begin
                    pwm_start = 1'b1;
                    if (idx_q == '0) begin
                        state_d  = STOP_HI;
                        pwm_stop = 1'b1;
                    end else begin
                        state_d = BIT_HI;
                        idx_d   = idx_q - IDX_W'(1);
                        pwm_bit = msg_q[idx_q - IDX_W'(1)];
                    end
                end
            end
            STOP_HI: begin
                if (pwm_done) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                if (cnt_q == SH_W'(IDLE_GAP - 1)) begin
                    state_d = READY;
                end else begin
                    cnt_d = cnt_q + SH_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // The MSB is presented and shifted out on every edge that lands in CFG_SHIFT
        if (state_d == CFG_SHIFT) begin
            sr_d = {sr_q[SR_W-2:0], 1'b0};
        end

        if (state_d == CFG_SHIFT) begin
            str_d = sr_q[SR_W-1];
        end else if (state_d inside {BIT_HI, BIT_LO, STOP_HI}) begin
            str_d = pwm_lvl;
        end else begin
            str_d = 1'b0;
        end
        mode_d      = state_d inside {CFG_LEAD, CFG_SHIFT};
        busy_d      = !(state_d inside {IDLE, READY});
        msg_ready_d = (state_d == READY) && cfg_done_d && !cfg_err_d;
    end

endmodule
